// File: rtl/instruction_loader.sv
// instruction_loader: streams a program into instruction_memory as a byte stream.
// Byte pairs arrive low byte first. Each pair is packed into one INST_W-bit word and
// written to consecutive addresses starting at base_addr. cpu_hold keeps the CPU in
// reset while a load is in progress.
// Optional feature: define INSTRUCTION_LOADER_CHECKSUM_EN to add a trailing checksum byte
// (an 8-bit modular sum of all data bytes) that is checked in a CHECK state and
// reported on checksum_err.
// Handshake: a byte moves on a rising edge where byte_valid && byte_ready. byte_ready is
// decoded from the state register only and never looks at byte_valid.
// INST_W is expected to equal 2*BYTE_W.
module instruction_loader #(
    parameter int INST_W   = 16,
    parameter int I_ADDR_W = 12,
    parameter int BYTE_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [I_ADDR_W-1:0] base_addr,
    input  logic [I_ADDR_W:0]   load_len,
    input  logic [BYTE_W-1:0]   byte_data,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic                wr_en,
    output logic [I_ADDR_W-1:0] wr_addr,
    output logic [INST_W-1:0]   wr_data,
    output logic                busy,
    output logic                cpu_hold,
    output logic                done,
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    output logic                checksum_err,
`endif
    output logic [2:0]          state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOW   = 3'd1,
        S_HIGH  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_CHECK = 3'd5
    } state_t;

    localparam logic [I_ADDR_W:0]   ONE_CNT  = 1;
    localparam logic [I_ADDR_W-1:0] ONE_ADDR = 1;

    state_t              state_q;
    logic [I_ADDR_W-1:0] addr_q;
    logic [I_ADDR_W:0]   len_q;
    logic [I_ADDR_W:0]   count_q;
    logic [BYTE_W-1:0]   lo_q;
    logic [BYTE_W-1:0]   hi_q;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]   sum_q;
`endif

    // Byte acceptance depends only on the current state.
    always_comb begin
        byte_ready = (state_q == S_LOW) || (state_q == S_HIGH) || (state_q == S_CHECK);
    end

    assign wr_addr   = addr_q;
    assign wr_data   = {hi_q, lo_q};
    assign cpu_hold  = busy;
    assign state_dbg = state_q;

    // Load sequencer. wr_en, done and busy are registered together with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            count_q      <= '0;
            lo_q         <= '0;
            hi_q         <= '0;
            wr_en        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            sum_q        <= '0;
            checksum_err <= 1'b0;
`endif
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q  <= base_addr;
                        len_q   <= load_len;
                        count_q <= '0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                        sum_q        <= '0;
                        checksum_err <= 1'b0;
                        // An empty load still carries a checksum byte (expected 0).
                        if (load_len == '0) begin
                            state_q <= S_CHECK;
                            busy    <= 1'b1;
                        end else begin
                            state_q <= S_LOW;
                            busy    <= 1'b1;
                        end
`else
                        if (load_len == '0) begin
                            state_q <= S_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_q <= S_LOW;
                            busy    <= 1'b1;
                        end
`endif
                    end
                end
                S_LOW: begin
                    if (byte_valid) begin
                        lo_q    <= byte_data;
                        state_q <= S_HIGH;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                        sum_q   <= sum_q + byte_data;
`endif
                    end
                end
                S_HIGH: begin
                    if (byte_valid) begin
                        hi_q    <= byte_data;
                        state_q <= S_WRITE;
                        wr_en   <= 1'b1;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                        sum_q   <= sum_q + byte_data;
`endif
                    end
                end
                S_WRITE: begin
                    // Address wraps silently at the top of memory.
                    addr_q  <= addr_q + ONE_ADDR;
                    count_q <= count_q + ONE_CNT;
                    if (count_q + ONE_CNT == len_q) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                        state_q <= S_CHECK;
`else
                        state_q <= S_DONE;
                        done    <= 1'b1;
                        busy    <= 1'b0;
`endif
                    end else begin
                        state_q <= S_LOW;
                    end
                end
                S_CHECK: begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                    if (byte_valid) begin
                        checksum_err <= (byte_data != sum_q);
                        state_q      <= S_DONE;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                    end
`else
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
`endif
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
